btn_event: RTL and testbench
============================

# btn_event

Button event classifier that sits directly downstream of the button debouncer. It consumes the debounced button level and a 1 ms tick enable. It produces single-cycle event pulses: press, short release, long-press and auto-repeat. The time-set logic uses these to step hours and minutes: one step per short press, fast stepping while the button is held.

## Interface
- `LONG_MS`, default 1000: number of tick_1ms pulses the button must be held before the long-press event; legal range 1..65535.
- `REPEAT_MS`, default 200: tick_1ms period between auto-repeat pulses after a long press; legal range 1..65535.
- `CW`, default 16: width of the internal tick counter; must satisfy 2^CW > max(LONG_MS, REPEAT_MS).
- `cclk`  in  1  system clock; all logic on rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `tick_1ms`  in  1  one-cclk-wide enable, once per millisecond, from the clock-divider stage.
- `btn_db`  in  1  debounced button level; 1 = pressed; synchronous to cclk.
- `press_p`  out  1  one-cycle pulse on a qualified press.
- `short_p`  out  1  one-cycle pulse on release before the long-press threshold.
- `long_p`  out  1  one-cycle pulse when the hold reaches LONG_MS ticks.
- `rpt_p`  out  1  one-cycle pulse every REPEAT_MS ticks after long_p while still held.
- `held`  out  1  level; 1 while state is not IDLE.

## Operation
- State register and counter:
  - States: IDLE, HOLD, REPEAT.
  - btn_q is a 1-cycle delayed copy of btn_db.
  - cnt is CW bits.
- All outputs are registered.
- Reset values:
  - state = IDLE, cnt = 0.
  - btn_q = 1. A button already held when clr deasserts produces no events until it is released and pressed again.
  - press_p, short_p, long_p, rpt_p, held = 0.
- IDLE:
  - If btn_db & ~btn_q: go to HOLD, set cnt = 0, press_p = 1 for the next cycle.
  - Otherwise stay in IDLE, ignore tick_1ms, keep cnt at 0.
- HOLD:
  - If btn_db == 0: go to IDLE, set short_p = 1, cnt = 0.
  - Else if tick_1ms and cnt == LONG_MS-1: go to REPEAT, set long_p = 1, cnt = 0.
  - Else if tick_1ms: cnt = cnt + 1.
- REPEAT:
  - If btn_db == 0: go to IDLE, cnt = 0. No short_p and no other pulse on this release.
  - Else if tick_1ms and cnt == REPEAT_MS-1: set rpt_p = 1, cnt = 0.
  - Else if tick_1ms: cnt = cnt + 1.
- Priority: release beats tick in the same cycle. A tick arriving in the same cycle as btn_db = 0 yields short_p (HOLD) or nothing (REPEAT), never long_p or rpt_p.
- No more than one event pulse is asserted in any cycle.
- A cnt wrap is unreachable given the CW constraint. No saturation logic is required.
- held is registered and equals (next state != IDLE).
- Reset asserted mid-operation: outputs go to 0 immediately and asynchronously, and any pending event is discarded.

## Timing
- Rising edge of btn_db sampled at cclk edge N: press_p and held are high during cycle N+1. press_p is exactly one cycle wide.
- long_p is high in the cycle after the LONG_MS-th tick_1ms following the press edge. A tick in the same cycle as the press edge is not counted (state is still IDLE).
- The first rpt_p comes REPEAT_MS ticks after the long_p tick. Later rpt_p pulses follow every REPEAT_MS ticks.
- Release sampled at edge M:
  - short_p (if in HOLD) and held = 0 are seen in cycle M+1.
  - A new press is accepted no earlier than edge M+1.
- Throughput: one press per 2 cclk cycles minimum (a high/low alternation of btn_db).

## Test plan
- LONG_MS=4, REPEAT_MS=2; btn_db rises, held 2 ticks, released -> press_p once, short_p once 1 cycle after release, no long_p.
- Same parameters; held 9 ticks -> press_p, long_p after tick 4, rpt_p after ticks 6 and 8, no short_p on release, held returns to 0.
- Release coinciding with the 4th tick -> short_p = 1, long_p stays 0; coinciding with a repeat tick -> no rpt_p.
- btn_db = 1 throughout clr deassert, then held 10 ticks, released, pressed again -> no events until the second press, which gives press_p.
- clr pulsed while in REPEAT -> all outputs 0 within the reset cycle, state IDLE; the button still held gives no press_p.
- tick_1ms held at 0 while the button is held -> only press_p, cnt frozen, no long_p.

Source files
------------

// File: rtl/btn_event.sv
// Button event classifier: turns the debounced button level into press,
// short-release, long-press and auto-repeat pulses for the time-set logic.
module btn_event #(
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200,
    parameter int unsigned CW        = 16
) (
    input  logic cclk,
    input  logic clr,
    input  logic tick_1ms,
    input  logic btn_db,
    output logic press_p,
    output logic short_p,
    output logic long_p,
    output logic rpt_p,
    output logic held
);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_MS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          btn_q;
    logic          press_n, short_n, long_n, rpt_n, held_n;

    // btn_q resets high so a button already down at reset needs a fresh press
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            btn_q   <= 1'b1;
            press_p <= 1'b0;
            short_p <= 1'b0;
            long_p  <= 1'b0;
            rpt_p   <= 1'b0;
            held    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            btn_q   <= btn_db;
            press_p <= press_n;
            short_p <= short_n;
            long_p  <= long_n;
            rpt_p   <= rpt_n;
            held    <= held_n;
        end
    end

    // Next state and event decode; a release always wins over a tick
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        press_n = 1'b0;
        short_n = 1'b0;
        long_n  = 1'b0;
        rpt_n   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (btn_db && !btn_q) begin
                    state_n = HOLD;
                    press_n = 1'b1;
                end
            end
            HOLD: begin
                if (!btn_db) begin
                    state_n = IDLE;
                    short_n = 1'b1;
                    cnt_n   = '0;
                end else if (tick_1ms && (cnt_q == LONG_LAST)) begin
                    state_n = REPEAT;
                    long_n  = 1'b1;
                    cnt_n   = '0;
                end else if (tick_1ms) begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            REPEAT: begin
                if (!btn_db) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (tick_1ms && (cnt_q == RPT_LAST)) begin
                    rpt_n = 1'b1;
                    cnt_n = '0;
                end else if (tick_1ms) begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        held_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event with LONG_MS=4, REPEAT_MS=2: directed
// stimulus queues expected pulses, a negedge monitor pops and compares them.
module tb_btn_event;

    localparam logic [3:0] EV_PRESS = 4'b1000;
    localparam logic [3:0] EV_SHORT = 4'b0100;
    localparam logic [3:0] EV_LONG  = 4'b0010;
    localparam logic [3:0] EV_RPT   = 4'b0001;

    typedef struct {
        logic [3:0] ev;
        int         cyc;
    } exp_t;

    logic cclk = 1'b0;
    logic clr;
    logic tick_1ms;
    logic btn_db;
    logic press_p, short_p, long_p, rpt_p, held;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    btn_event #(.LONG_MS(4), .REPEAT_MS(2), .CW(16)) dut (
        .cclk     (cclk),
        .clr      (clr),
        .tick_1ms (tick_1ms),
        .btn_db   (btn_db),
        .press_p  (press_p),
        .short_p  (short_p),
        .long_p   (long_p),
        .rpt_p    (rpt_p),
        .held     (held)
    );

    always #5 cclk = ~cclk;
    always @(posedge cclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Apply inputs, let the DUT sample them at the next edge, settle 1 time unit
    task automatic drv(input logic b, input logic t);
        btn_db   = b;
        tick_1ms = t;
        @(posedge cclk);
        #1;
    endtask

    task automatic expect_ev(input logic [3:0] ev);
        exp_t e;
        e.ev  = ev;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Hold the button for n ticks, each tick followed by an idle cycle
    task automatic ticks_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            drv(1'b1, 1'b1);
            drv(1'b1, 1'b0);
        end
    endtask

    // Monitor: any pulse must match the oldest expected event and its cycle
    always @(negedge cclk) begin
        logic [3:0] act;
        exp_t e;
        act = {press_p, short_p, long_p, rpt_p};
        if (act != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(act), 0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", int'(act), int'(e.ev));
                check("event_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        clr = 1'b1;
        btn_db = 1'b0;
        tick_1ms = 1'b0;
        repeat (3) @(posedge cclk);
        #1;
        check("reset_outputs", int'({press_p, short_p, long_p, rpt_p, held}), 0);
        clr = 1'b0;
        drv(1'b0, 1'b0);

        // Short press: 2 ticks then release
        drv(1'b1, 1'b1);
        expect_ev(EV_PRESS);
        check("held_after_press", int'(held), 1);
        ticks_quiet(2);
        drv(1'b0, 1'b0);
        expect_ev(EV_SHORT);
        check("held_after_short", int'(held), 0);
        drv(1'b0, 1'b0);

        // Long hold for 9 ticks: long at 4, repeat at 6 and 8
        drv(1'b1, 1'b0);
        expect_ev(EV_PRESS);
        ticks_quiet(3);
        drv(1'b1, 1'b1);
        expect_ev(EV_LONG);
        drv(1'b1, 1'b0);
        ticks_quiet(1);
        drv(1'b1, 1'b1);
        expect_ev(EV_RPT);
        drv(1'b1, 1'b0);
        ticks_quiet(1);
        drv(1'b1, 1'b1);
        expect_ev(EV_RPT);
        drv(1'b1, 1'b0);
        ticks_quiet(1);
        check("held_in_repeat", int'(held), 1);
        drv(1'b0, 1'b0);
        check("held_after_long_release", int'(held), 0);
        drv(1'b0, 1'b0);

        // Release on the 4th tick gives short, not long
        drv(1'b1, 1'b0);
        expect_ev(EV_PRESS);
        ticks_quiet(3);
        drv(1'b0, 1'b1);
        expect_ev(EV_SHORT);
        drv(1'b0, 1'b0);

        // Release on a repeat tick gives nothing
        drv(1'b1, 1'b0);
        expect_ev(EV_PRESS);
        ticks_quiet(3);
        drv(1'b1, 1'b1);
        expect_ev(EV_LONG);
        ticks_quiet(1);
        drv(1'b0, 1'b1);
        check("held_after_rpt_tick_release", int'(held), 0);
        drv(1'b0, 1'b0);

        // Button already held through reset release: no events until a new press
        btn_db = 1'b1;
        clr = 1'b1;
        repeat (2) @(posedge cclk);
        #1;
        clr = 1'b0;
        ticks_quiet(10);
        check("held_preheld", int'(held), 0);
        drv(1'b0, 1'b0);
        drv(1'b0, 1'b0);
        drv(1'b1, 1'b0);
        expect_ev(EV_PRESS);
        drv(1'b0, 1'b0);
        expect_ev(EV_SHORT);

        // Reset while a repeat pulse is showing: cleared at once, no re-press
        drv(1'b1, 1'b0);
        expect_ev(EV_PRESS);
        ticks_quiet(3);
        drv(1'b1, 1'b1);
        expect_ev(EV_LONG);
        ticks_quiet(1);
        drv(1'b1, 1'b1);
        clr = 1'b1;
        #1;
        check("clr_async_outputs", int'({press_p, short_p, long_p, rpt_p, held}), 0);
        @(posedge cclk);
        #1;
        clr = 1'b0;
        ticks_quiet(6);
        check("held_after_clr", int'(held), 0);
        drv(1'b0, 1'b0);

        // No ticks: counter frozen, no long press
        drv(1'b1, 1'b0);
        expect_ev(EV_PRESS);
        repeat (20) drv(1'b1, 1'b0);
        check("held_no_tick", int'(held), 1);
        drv(1'b0, 1'b0);
        expect_ev(EV_SHORT);

        // Fastest alternation: press every 2 cycles
        drv(1'b1, 1'b0);
        expect_ev(EV_PRESS);
        drv(1'b0, 1'b0);
        expect_ev(EV_SHORT);
        drv(1'b1, 1'b1);
        expect_ev(EV_PRESS);
        drv(1'b0, 1'b1);
        expect_ev(EV_SHORT);

        repeat (4) drv(1'b0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
